// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event path.
//   - btn_state_t : classifier FSM states (3-bit encoding)
//   - DEFAULT_*   : default timing constants for a 50 MHz system clock
//   - max3        : constant helper used to size the shared counter
// ---------------------------------------------------------------------------
package button_pkg;

    // Classifier states. The encoding is fixed so the state register can be
    // read directly when probing the design in the lab.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESSED     = 3'd1,
        LONG_HELD   = 3'd2,
        WAIT_GAP    = 3'd3,
        SECOND_HELD = 3'd4
    } btn_state_t;

    localparam int CLK_HZ                 = 50_000_000;
    localparam int DEFAULT_LONG_CYCLES    = 50_000_000;  // 1 s hold
    localparam int DEFAULT_GAP_CYCLES     = 15_000_000;  // 300 ms double-click window
    localparam int DEFAULT_REPEAT_CYCLES  = 10_000_000;  // 200 ms auto-repeat period

    // Largest of three timing values; sizes the counter shared by all states.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/button_edge_detect.sv
// ---------------------------------------------------------------------------
// button_edge_detect
// Registers the previous button level and reports rising/falling edges
// combinationally against the current level. Reused by any consumer of a
// debounced button that needs edge information.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (prev clears to 0)
//   level in  debounced, clk-synchronous button level
//   rise  out level & ~prev
//   fall  out ~level & prev
// ---------------------------------------------------------------------------
module button_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    // Because prev resets to 0, a button already held when reset releases is
    // reported as a rise on the first sampling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/button_event_classifier.sv
// ---------------------------------------------------------------------------
// button_event_classifier
// Turns a clean button level into single-cycle event pulses for menu/game
// logic. One instance per button.
// Parameters:
//   LONG_CYCLES   hold time for a long press (>= 2)
//   GAP_CYCLES    max release-to-press gap for a double click (>= 2)
//   REPEAT_CYCLES auto-repeat period after a long press, 0 disables repeat
// Ports:
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   btn_level     in  debounced button level, synchronous to clk
//   press_pulse   out pulse on every rising edge
//   release_pulse out pulse on every falling edge
//   short_press   out pulse for a lone press that was not long
//   long_press    out pulse when the hold reaches LONG_CYCLES
//   repeat_pulse  out periodic pulses while held after a long press
//   double_click  out pulse on the second press of a double click
//   held          out high in PRESSED, LONG_HELD and SECOND_HELD
// All outputs are registered.
// ---------------------------------------------------------------------------
module button_event_classifier
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic held
);

    localparam int MAX_CYCLES = max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Terminal counts. The repeat terminal is forced to 0 when repeat is off
    // so the expression never goes negative; it is then never consulted.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST =
        CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);

    logic             rise;
    logic             fall;
    btn_state_t       state;
    logic [CNT_W-1:0] count;

    button_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (btn_level),
        .rise  (rise),
        .fall  (fall)
    );

    // Single FSM block: state, shared counter and all output registers.
    // Pulse outputs default low every cycle so each event lasts one cycle.
    // Edges are tested before terminal counts, so a release on the long
    // terminal edge stays a short press and a rise on the gap terminal edge
    // becomes a double click. The counter only advances in states that have
    // a terminal count, which keeps it from ever wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;

            case (state)
                IDLE: begin
                    count <= '0;
                    if (rise) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end

                PRESSED: begin
                    if (fall) begin
                        state         <= WAIT_GAP;
                        count         <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (count == LONG_LAST) begin
                        state      <= LONG_HELD;
                        count      <= '0;
                        long_press <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                LONG_HELD: begin
                    if (fall) begin
                        state         <= IDLE;
                        count         <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (REPEAT_EN && (count == REPEAT_LAST)) begin
                        count        <= '0;
                        repeat_pulse <= 1'b1;
                    end else if (REPEAT_EN) begin
                        count <= count + 1'b1;
                    end
                end

                WAIT_GAP: begin
                    if (rise) begin
                        state        <= SECOND_HELD;
                        count        <= '0;
                        press_pulse  <= 1'b1;
                        double_click <= 1'b1;
                        held         <= 1'b1;
                    end else if (count == GAP_LAST) begin
                        state       <= IDLE;
                        count       <= '0;
                        short_press <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                SECOND_HELD: begin
                    count <= '0;
                    if (fall) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_event_classifier.md
# button_event_classifier

Downstream consumer of the debounced button level. Turns a clean, glitch-free button level into single-cycle event pulses for the game/menu logic: press, release, short press, long press, auto-repeat while held, and double click. Sits between the debouncer output and the control FSMs, one instance per button.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time for a long press (1 s at 50 MHz); must be ≥ 2.
- `GAP_CYCLES`, default 15_000_000: maximum gap between a release and a second press that counts as a double click (300 ms); must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after a long press; 0 disables repeat.
- `clk`, in, 1: system clock, all logic on posedge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_level`, in, 1: debounced button level, already synchronous to `clk`.
- `press_pulse`, out, 1: one-cycle pulse on every rising edge of `btn_level`.
- `release_pulse`, out, 1: one-cycle pulse on every falling edge.
- `short_press`, out, 1: one-cycle pulse for a single press that was neither long nor followed by a second press.
- `long_press`, out, 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse`, out, 1: periodic pulses while held after a long press.
- `double_click`, out, 1: one-cycle pulse on the second press.
- `held`, out, 1: level, high in PRESSED, LONG_HELD and SECOND_HELD.

## Operation
- Edge detection uses a `prev` register, reset 0. Rise is `btn_level & ~prev`; fall is `~btn_level & prev`.
- The counter is shared by all states. Its width is `$clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)+1)`. It clears on every state entry and increments on each edge spent in the state. It never wraps, because every terminal count forces a state exit or a counter clear.
- FSM states and transitions:
  - IDLE:
    - rise → PRESSED; pulse `press_pulse`.
  - PRESSED:
    - fall → WAIT_GAP; pulse `release_pulse`.
    - Otherwise, counter == LONG_CYCLES-1 → LONG_HELD; pulse `long_press`.
  - LONG_HELD:
    - fall → IDLE; pulse `release_pulse`. No `short_press`.
    - Otherwise, if REPEAT_CYCLES ≠ 0 and counter == REPEAT_CYCLES-1 → pulse `repeat_pulse` and clear the counter.
  - WAIT_GAP:
    - rise → SECOND_HELD; pulse `press_pulse` and `double_click`.
    - Otherwise, counter == GAP_CYCLES-1 → IDLE; pulse `short_press`.
  - SECOND_HELD:
    - fall → IDLE; pulse `release_pulse`.
    - No long press and no repeat from this state.
- Simultaneous events, edge beats timeout:
  - Release on the long-press terminal edge gives a short press, not a long press.
  - Rise on the gap terminal edge gives a double click, not a short press.
- Reset mid-operation: all outputs, `prev`, counter and state go to 0/IDLE immediately, and no pulse is emitted. If the button is held when `rst_n` releases, the first sampled high is treated as a rise.

## Timing
- All outputs are registered. Each pulse is high for exactly one cycle, in the cycle after the sampling edge that caused it.
- Reset values: every output is 0.
- `press_pulse` is high 1 cycle after the first edge that samples `btn_level` high.
- `long_press` is high exactly LONG_CYCLES cycles after `press_pulse`.
- `repeat_pulse` fires every REPEAT_CYCLES cycles, the first one REPEAT_CYCLES cycles after `long_press`.
- `short_press` is high exactly GAP_CYCLES cycles after `release_pulse`.
- `double_click` and its `press_pulse` are in the same cycle.
- `held` follows the state register (1-cycle latency from the edge).

## Structure
- Shared package `button_pkg`:
  - state enum IDLE=0, PRESSED=1, LONG_HELD=2, WAIT_GAP=3, SECOND_HELD=4 (3-bit encoding);
  - default timing constants at 50 MHz.
- One natural sub-module, `button_edge_detect`: the `prev` register with rise/fall outputs, async active-low reset, reused by other button consumers.
- FSM, counter and output registers live in the top module.

## Test plan
Bench parameters: LONG_CYCLES=8, GAP_CYCLES=5, REPEAT_CYCLES=3.
- Short press: hold high for 3 cycles, then low for 10 → `press_pulse`, `release_pulse`, then `short_press` 5 cycles after release; no other pulses.
- Long press with repeat: hold high for 20 cycles → `long_press` 8 cycles after `press_pulse`; `repeat_pulse` at +3, +6, +9 after it; `release_pulse` on fall; no `short_press`.
- Double click: high 2, low 3, high 2, low 10 → second rise gives `press_pulse` and `double_click` together; no `short_press`, no `long_press`.
- Boundary edges:
  - release exactly on the 8th held cycle → `short_press` path, no `long_press`;
  - second rise exactly on the 5th gap cycle → `double_click`, no `short_press`.
- Reset mid-hold: assert `rst_n`=0 in LONG_HELD → all outputs 0 immediately; release reset with the button high → `press_pulse` 1 cycle after the first sampling edge.
- REPEAT_CYCLES=0 build: hold 30 cycles → single `long_press`, zero `repeat_pulse`.
